l2_backing_memory: RTL and testbench



---
 rtl/l2_backing_memory.sv | 129 ++++++++++++
 tb/tb_l2_backing_memory.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_backing_memory.sv
// rtl/l2_backing_memory.sv - block-granular main memory responder with fixed response latency
// Optional macro MEM_STATS_EN adds saturating rd_count/wr_count outputs.
module l2_backing_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int BLOCK_SIZE = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int LATENCY    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDR_WIDTH-1:0]                 mem_addr,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_in,
  input  logic                                  mem_read,
  input  logic                                  mem_write,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_block,
  output logic                                  mem_ready
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]                           rd_count,
  output logic [15:0]                           wr_count
`endif
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx_q, resp_idx;
  logic             wr_q, resp_wr, accept, enter_resp, unused_addr;
  block_t           data_q, resp_data, stored;
  block_t           mem [MEM_DEPTH];
  // A block never written reads as its power-up pattern; these flags survive reset.
  logic [MEM_DEPTH-1:0] written = '0;

  function automatic block_t init_block(input logic [IDX_W-1:0] b);
    logic [31:0] v;
    init_block = '0;
    for (int w = 0; w < BLOCK_SIZE; w++) begin
      v = {16'(b), 16'(w)};
      init_block[w] = DATA_WIDTH'(v);
    end
  endfunction

  assign unused_addr = ^mem_addr;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    mem_ready = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = RESP;
      end
      RESP: begin
        mem_ready = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY==1 the response is formed on the accepting edge, so bypass the latches.
  assign enter_resp = (state_nxt == RESP) && (state != RESP);
  assign resp_idx   = (state == IDLE) ? mem_addr[IDX_W-1:0] : idx_q;
  assign resp_wr    = (state == IDLE) ? mem_write : wr_q;
  assign resp_data  = (state == IDLE) ? mem_data_in : data_q;
  assign stored     = written[resp_idx] ? mem[resp_idx] : init_block(resp_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      idx_q          <= '0;
      wr_q           <= 1'b0;
      data_q         <= '0;
      mem_data_block <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        idx_q  <= mem_addr[IDX_W-1:0];
        wr_q   <= mem_write;
        data_q <= mem_data_in;
      end
      if (enter_resp) mem_data_block <= resp_wr ? resp_data : stored;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && resp_wr) begin
      mem[resp_idx]     <= resp_data;
      written[resp_idx] <= 1'b1;
    end
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == RESP) begin
      if (wr_q) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l2_backing_memory.sv
// tb/tb_l2_backing_memory.sv - randomized and directed bench for l2_backing_memory
// Behavioural memory model checked every cycle, plus literal expectations.
module tb_l2_backing_memory;

  localparam int LAT = 4;
  typedef logic [31:0][31:0] blk_t;

  logic        clk;
  logic        rst_n;
  logic [10:0] mem_addr;
  blk_t        mem_data_in;
  logic        mem_read;
  logic        mem_write;
  blk_t        mem_data_block;
  logic        mem_ready;

  int checks = 0;
  int fails  = 0;

  l2_backing_memory dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_data_block (mem_data_block),
    .mem_ready      (mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: block store plus the edge numbers at which responses fall due.
  blk_t mdl [256];
  int   edge_n     = 0;
  int   next_free  = 0;
  int   resp_edge  = 0;
  int   ready_edge = -1;
  bit   pend       = 0;
  bit   p_wr       = 0;
  int   p_idx      = 0;
  blk_t p_data;
  blk_t exp_block  = '0;

  initial begin
    for (int b = 0; b < 256; b++)
      for (int w = 0; w < 32; w++)
        mdl[b][w] = {16'(b), 16'(w)};
  end

  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) begin
      pend       = 0;
      next_free  = edge_n + 1;
      ready_edge = -1;
      exp_block  = '0;
    end else begin
      if (!pend && edge_n >= next_free && (mem_read || mem_write)) begin
        pend      = 1;
        p_wr      = mem_write;
        p_idx     = int'(mem_addr[7:0]);
        p_data    = mem_data_in;
        resp_edge = edge_n + LAT - 1;
        next_free = edge_n + LAT + 1;
      end
      if (pend && edge_n == resp_edge) begin
        if (p_wr) mdl[p_idx] = p_data;
        exp_block  = mdl[p_idx];
        ready_edge = edge_n;
        pend       = 0;
      end
    end
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkblk(input string name, input blk_t act, input blk_t exp);
    int w;
    checks++;
    if (act !== exp) begin
      fails++;
      w = 0;
      while (w < 31 && act[w] === exp[w]) w++;
      $display("FAIL %s: word %0d got %h expected %h", name, w, act[w], exp[w]);
    end
  endtask

  always @(negedge clk) begin
    chk32("ready_vs_model", 32'(mem_ready), 32'(ready_edge == edge_n));
    chkblk("block_vs_model", mem_data_block, exp_block);
  end

  // Issue one request; hold keeps it asserted (with scrambled inputs) until mem_ready.
  task automatic req_wait(input bit rd, input bit wr, input logic [10:0] a, input blk_t d,
                          input bit hold, output blk_t resp, output int lat);
    @(negedge clk);
    #1;
    mem_read = rd; mem_write = wr; mem_addr = a; mem_data_in = d;
    lat  = 0;
    resp = '0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        lat  = i;
        resp = mem_data_block;
      end
      #1;
      if (!hold || lat != 0) begin
        mem_read = 1'b0; mem_write = 1'b0;
      end else begin
        mem_addr = 11'($urandom);
        for (int w = 0; w < 32; w++) mem_data_in[w] = $urandom;
      end
      if (lat != 0) break;
    end
    if (lat == 0) chk32("req_timeout", 32'(lat), 32'(LAT));
  endtask

  task automatic wait_ready(input string name, output blk_t resp);
    bit got = 0;
    resp = '0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        got  = 1;
        resp = mem_data_block;
      end
    end
    if (!got) chk32(name, 32'd0, 32'd1);
  endtask

  initial begin
    #400000;
    fails++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    blk_t resp, d;
    int   lat;
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_data_in = '0;
    repeat (3) @(negedge clk);
    chk32("reset_ready", 32'(mem_ready), 32'd0);
    chkblk("reset_block", mem_data_block, '0);
    #1 rst_n = 1'b1;

    req_wait(1, 0, 11'h00A, '0, 0, resp, lat);
    chk32("t1_latency", 32'(lat), 32'd4);
    chk32("t1_word0", resp[0], 32'h000A0000);
    chk32("t1_word31", resp[31], 32'h000A001F);

    for (int i = 0; i < 32; i++) d[i] = 32'hA5A5A5A5 ^ 32'(i);
    req_wait(0, 1, 11'h014, d, 0, resp, lat);
    chkblk("t2_write_echo", resp, d);
    req_wait(1, 0, 11'h014, '0, 0, resp, lat);
    chk32("t2_word0", resp[0], 32'hA5A5A5A5);
    chk32("t2_word5", resp[5], 32'hA5A5A5A0);

    d = {32{32'h5A5A5A5A}};
    req_wait(0, 1, 11'h10A, d, 0, resp, lat);
    req_wait(1, 0, 11'h00A, '0, 0, resp, lat);
    chkblk("t3_alias", resp, d);

    @(negedge clk);
    #1 mem_read = 1'b1; mem_addr = 11'h001;
    @(negedge clk);
    #1 mem_addr = 11'h002;
    wait_ready("t4_first_timeout", resp);
    chk32("t4_first_word0", resp[0], 32'h00010000);
    wait_ready("t4_second_timeout", resp);
    chk32("t4_second_word0", resp[0], 32'h00020000);
    #1 mem_read = 1'b0;

    @(negedge clk);
    #1 mem_write = 1'b1; mem_addr = 11'h030;
    for (int w = 0; w < 32; w++) mem_data_in[w] = $urandom;
    @(negedge clk);
    #1 mem_write = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk32("t5_ready_in_reset", 32'(mem_ready), 32'd0);
    end
    #1 rst_n = 1'b1;
    req_wait(1, 0, 11'h030, '0, 0, resp, lat);
    chk32("t5_word0", resp[0], 32'h00300000);

    for (int n = 0; n < 150; n++) begin
      bit rd, wr, hold;
      logic [10:0] a;
      int op = $urandom_range(0, 3);
      rd   = (op == 0 || op == 3);
      wr   = (op == 1 || op == 2 || op == 3);
      hold = ($urandom_range(0, 3) == 0);
      a    = 11'($urandom_range(0, 7)) | (11'($urandom_range(0, 7)) << 8);
      for (int w = 0; w < 32; w++) d[w] = $urandom;
      req_wait(rd, wr, a, d, hold, resp, lat);
      chk32("rand_latency", 32'(lat), 32'(LAT));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
